// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: loader state encoding and word-sizing helper shared by prog_loader files
package prog_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR} state_t;
  function automatic int bytes_per_word(input int xlen);
    return xlen / 8;
  endfunction
endpackage

// File: rtl/prog_loader_byte_word_assembler.sv
// prog_loader_byte_word_assembler: packs little-endian bytes into XLEN words
// Ports: clk, nrst (async active-low); clr restarts the byte count; en consumes data;
//   word is the assembled word including the current byte, word_valid marks its last byte.
module prog_loader_byte_word_assembler
  import prog_loader_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            clr,
  input  logic            en,
  input  logic [7:0]      data,
  output logic [XLEN-1:0] word,
  output logic            word_valid
);
  localparam int BPW = bytes_per_word(XLEN);
  localparam int IW = $clog2(BPW + 1);
  logic [IW-1:0]   idx;
  logic [XLEN-1:0] sr;
  // each new byte enters at the top and shifts down, so the first byte lands in [7:0]
  generate
    if (XLEN == 8) begin : g_byte
      assign word = data;
    end else begin : g_word
      assign word = {data, sr[XLEN-1:8]};
    end
  endgenerate
  assign word_valid = en && idx == IW'(BPW - 1);
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx <= '0;
      sr  <= '0;
    end else if (clr) begin
      idx <= '0;
      sr  <= '0;
    end else if (en) begin
      idx <= word_valid ? '0 : idx + IW'(1);
      sr  <= word;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// prog_loader: loads a length-prefixed little-endian byte stream into instruction memory
// Optional PROG_LOADER_CHECKSUM_EN: a trailing XLEN word must equal the sum of all data words.
// Ports: clk, nrst (async active-low); load_req starts a load from IDLE/DONE/ERR;
//   rx_valid/rx_data/rx_ready byte stream in; mem_we/mem_addr/mem_wdata/mem_ready memory write;
//   core_halt/core_run core control; load_err last load failed; words_loaded words written.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int ADDR_W    = 32,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ready,
  output logic              core_halt,
  output logic              core_run,
  output logic              load_err,
  output logic [ADDR_W-1:0] words_loaded
);
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t LAST = CSUM;
  logic [XLEN-1:0] acc;
`else
  localparam state_t LAST = DONE;
`endif
  state_t            state;
  logic [ADDR_W-1:0] count;
  logic [XLEN-1:0]   word;
  logic              word_valid;
  logic              start;
  logic              last_write;
  assign rx_ready   = state inside {HDR, DATA, CSUM};
  assign start      = load_req && state inside {IDLE, DONE, ERR};
  assign last_write = words_loaded + ADDR_W'(1) == count;
  prog_loader_byte_word_assembler #(.XLEN(XLEN)) u_asm (
    .clk        (clk),
    .nrst       (nrst),
    .clr        (start),
    .en         (rx_valid && rx_ready),
    .data       (rx_data),
    .word       (word),
    .word_valid (word_valid)
  );
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= IDLE;
      core_halt    <= 1'b1;
      core_run     <= 1'b0;
      load_err     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= ADDR_W'(BASE_ADDR);
      mem_wdata    <= '0;
      words_loaded <= '0;
      count        <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc          <= '0;
`endif
    end else if (start) begin
      state        <= HDR;
      core_halt    <= 1'b1;
      core_run     <= 1'b0;
      load_err     <= 1'b0;
      mem_addr     <= ADDR_W'(BASE_ADDR);
      words_loaded <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      acc          <= '0;
`endif
    end else begin
      case (state)
        HDR: if (word_valid) begin
          count    <= ADDR_W'(word);
          load_err <= word > XLEN'(DEPTH);
          state    <= word == '0 ? LAST : word > XLEN'(DEPTH) ? ERR : DATA;
        end
        DATA: if (word_valid) begin
          mem_wdata <= word;
          mem_we    <= 1'b1;
          state     <= WRITE;
        end
        // address and data stay put until the memory takes the word
        WRITE: if (mem_ready) begin
          mem_we       <= 1'b0;
          words_loaded <= words_loaded + ADDR_W'(1);
          mem_addr     <= mem_addr + ADDR_W'(1);
`ifdef PROG_LOADER_CHECKSUM_EN
          acc          <= acc + mem_wdata;
`endif
          state        <= last_write ? LAST : DATA;
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        CSUM: if (word_valid) begin
          load_err <= word != acc;
          state    <= word == acc ? DONE : ERR;
        end
`endif
        DONE: begin
          core_halt <= 1'b0;
          core_run  <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed table-driven bench for prog_loader plus stall/reset/ignore sequences
module tb_prog_loader;
  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h40;
  logic        clk = 0, nrst = 0, load_req = 0, rx_valid = 0, mem_ready = 1;
  logic [7:0]  rx_data = 0;
  logic        rx_ready, mem_we, core_halt, core_run, load_err;
  logic [31:0] mem_addr, mem_wdata, words_loaded;
  int          checks = 0, errors = 0;
  logic [63:0] wq [$];
  typedef struct packed {
    logic [31:0]       cnt;
    logic [3:0][31:0]  w;
    logic [31:0]       csum;
    logic              exp_err;
    logic [31:0]       exp_wl;
  } vec_t;
  vec_t tv [8];
  int   nv = 0;

  always #5 clk = ~clk;

  prog_loader #(.XLEN(32), .ADDR_W(32), .DEPTH(DEPTH), .BASE_ADDR(32'h40)) dut (
    .clk(clk), .nrst(nrst), .load_req(load_req), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .core_halt(core_halt), .core_run(core_run), .load_err(load_err),
    .words_loaded(words_loaded)
  );

  always @(posedge clk) if (nrst && mem_we && mem_ready) wq.push_back({mem_addr, mem_wdata});

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [31:0] c, w0, w1, w2, w3, cs, input logic e, input logic [31:0] wl);
    tv[nv].cnt = c;
    tv[nv].w[0] = w0;
    tv[nv].w[1] = w1;
    tv[nv].w[2] = w2;
    tv[nv].w[3] = w3;
    tv[nv].csum = cs;
    tv[nv].exp_err = e;
    tv[nv].exp_wl = wl;
    nv++;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1;
    rx_data = b;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("FAIL rx_wait: rx_ready got 0 expected 1");
    end
    @(negedge clk);
    rx_valid = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_core_halt"}, core_halt, 1);
    chk({tag, "_core_run"}, core_run, 0);
    chk({tag, "_load_err"}, load_err, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_addr"}, mem_addr, BASE);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rx_ready"}, rx_ready, 0);
    chk({tag, "_words_loaded"}, words_loaded, 0);
  endtask

  task automatic start_load();
    wq.delete();
    load_req = 1;
    @(negedge clk);
    load_req = 0;
    chk("start_load_err", load_err, 0);
    chk("start_core_halt", core_halt, 1);
    chk("start_core_run", core_run, 0);
    chk("start_words_loaded", words_loaded, 0);
    chk("start_mem_addr", mem_addr, BASE);
    chk("start_rx_ready", rx_ready, 1);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    start_load();
    send_word(v.cnt);
    if (v.cnt <= DEPTH) begin
      for (int i = 0; i < int'(v.cnt); i++) send_word(v.w[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
      send_word(v.csum);
`endif
    end
    repeat (3) @(negedge clk);
    chk($sformatf("v%0d_words_loaded", k), words_loaded, v.exp_wl);
    chk($sformatf("v%0d_load_err", k), load_err, v.exp_err);
    chk($sformatf("v%0d_core_run", k), core_run, !v.exp_err);
    chk($sformatf("v%0d_core_halt", k), core_halt, v.exp_err);
    chk($sformatf("v%0d_mem_we", k), mem_we, 0);
    chk($sformatf("v%0d_write_count", k), wq.size(), v.exp_wl);
    for (int i = 0; i < wq.size() && i < int'(v.exp_wl); i++)
      chk($sformatf("v%0d_write%0d", k, i), wq[i], {BASE + 32'(i), v.w[i]});
  endtask

  initial begin
    add(1, 32'h002081B3, 0, 0, 0, 32'h002081B3, 0, 1);
    add(2, 32'hFFFFFFFF, 32'h2, 0, 0, 32'h1, 0, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(DEPTH + 1, 0, 0, 0, 0, 0, 1, 0);
    add(3, 32'h1, 32'h2, 32'h3, 0, 32'h6, 0, 3);
    add(DEPTH, 32'h10, 32'h20, 32'h30, 32'h40, 32'hA0, 0, 4);
`ifdef PROG_LOADER_CHECKSUM_EN
    add(2, 32'h1, 32'h2, 0, 0, 32'h3, 0, 2);
    add(2, 32'h1, 32'h2, 0, 0, 32'h4, 1, 2);
`endif
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    nrst = 1;
    @(negedge clk);
    rx_valid = 1;
    rx_data = 8'hAA;
    repeat (2) @(negedge clk);
    chk("idle_rx_ready", rx_ready, 0);
    rx_valid = 0;
    for (int k = 0; k < nv; k++) run_vec(k, tv[k]);

    // write stall of three cycles, with an ignored load_req in the middle
    mem_ready = 0;
    start_load();
    send_word(2);
    send_word(32'h12345678);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("stall%0d_mem_we", i), mem_we, 1);
      chk($sformatf("stall%0d_mem_addr", i), mem_addr, BASE);
      chk($sformatf("stall%0d_mem_wdata", i), mem_wdata, 32'h12345678);
      chk($sformatf("stall%0d_rx_ready", i), rx_ready, 0);
      load_req = (i == 1);
      mem_ready = (i == 3);
      @(negedge clk);
    end
    chk("stall_after_mem_we", mem_we, 0);
    chk("stall_after_words_loaded", words_loaded, 1);
    chk("stall_after_mem_addr", mem_addr, BASE + 1);
    chk("stall_after_writes", wq.size(), 1);
    send_word(32'h9ABCDEF0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'hACF13568);
`endif
    repeat (3) @(negedge clk);
    chk("stall_write_count", wq.size(), 2);
    if (wq.size() == 2) chk("stall_write1", wq[1], {BASE + 32'd1, 32'h9ABCDEF0});
    chk("stall_core_run", core_run, 1);
    chk("stall_words_loaded", words_loaded, 2);

    // asynchronous reset after two of four data bytes, then a clean reload
    start_load();
    send_word(1);
    send_byte(8'h0D);
    send_byte(8'hF0);
    #2 nrst = 0;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    nrst = 1;
    @(negedge clk);
    start_load();
    send_word(1);
    send_word(32'hCAFEF00D);
`ifdef PROG_LOADER_CHECKSUM_EN
    send_word(32'hCAFEF00D);
`endif
    repeat (3) @(negedge clk);
    chk("reload_write_count", wq.size(), 1);
    if (wq.size() == 1) chk("reload_write0", wq[0], {BASE, 32'hCAFEF00D});
    chk("reload_core_run", core_run, 1);
    chk("reload_core_halt", core_halt, 0);
    chk("reload_words_loaded", words_loaded, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
